// File: rtl/proc_pkg.sv
// Shared definitions for the processor control path: opcodes, step encoding
// and the width of the register select vectors.
package proc_pkg;

    localparam int REG_SEL_W = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Instruction step; the encoding is fixed so T0..T3 read as 00..11
    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

endpackage

// File: rtl/bus_controller_dec3to8.sv
// 3-to-8 one-hot decoder, MSB-first: index 0 selects bit 7 (R0), index 7
// selects bit 0 (R7). Output is all zeros when the enable is low.
module dec3to8
    import proc_pkg::*;
(
    input  logic [2:0]           idx_i,
    input  logic                 en_i,
    output logic [REG_SEL_W-1:0] onehot_o
);

    localparam logic [REG_SEL_W-1:0] MSB_ONLY = 8'b1000_0000;

    // Shift a single bit down from the MSB by the register index
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = MSB_ONLY >> idx_i;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// Control unit for the datapath bus: fetches a 9-bit instruction (III XXX YYY)
// from DIN, steps through T0..T3 and decodes the bus-driver selects and
// register load enables for each step.
module bus_controller
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Run,
    input  logic [DATA_W-1:0]    DIN,
    output logic [REG_SEL_W-1:0] Rout,
    output logic                 Gout,
    output logic                 DINout,
    output logic [REG_SEL_W-1:0] Rin,
    output logic                 Ain,
    output logic                 Gin,
    output logic                 IRin,
    output logic                 AddSub,
    output logic                 Done
);

    step_t       step_q, step_d;
    logic [8:0]  ir_q, ir_d;

    logic [2:0]           opcode;
    logic [2:0]           regX;
    logic [2:0]           regY;
    logic [REG_SEL_W-1:0] xOneHot;
    logic [REG_SEL_W-1:0] yOneHot;
    logic                 unusedDin;

    assign opcode    = ir_q[8:6];
    assign regX      = ir_q[5:3];
    assign regY      = ir_q[2:0];

    // Only the low nine bits of DIN carry an instruction
    assign unusedDin = ^DIN[DATA_W-1:9];

    // Decoders are held off during reset so no select can glitch high
    dec3to8 u_decX (
        .idx_i    (regX),
        .en_i     (Resetn),
        .onehot_o (xOneHot)
    );

    dec3to8 u_decY (
        .idx_i    (regY),
        .en_i     (Resetn),
        .onehot_o (yOneHot)
    );

    // Step register and instruction register; reset aborts any instruction
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Moore decode of step and IR into selects, enables and the next step
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        Rout   = '0;
        Rin    = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        IRin   = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        unique case (step_q)
            T0: begin
                IRin = Run & Resetn;
                if (Run) begin
                    ir_d   = DIN[8:0];
                    step_d = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout   = yOneHot;
                        Rin    = xOneHot;
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = xOneHot;
                        Done   = 1'b1;
                        step_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout   = xOneHot;
                        Ain    = 1'b1;
                        step_d = T2;
                    end
                    default: begin
                        Done   = 1'b1;
                        step_d = T0;
                    end
                endcase
            end
            T2: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    Rout   = yOneHot;
                    Gin    = 1'b1;
                    AddSub = (opcode == OP_SUB);
                    step_d = T3;
                end else begin
                    step_d = T0;
                end
            end
            T3: begin
                Gout   = 1'b1;
                Rin    = xOneHot;
                Done   = 1'b1;
                step_d = T0;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

endmodule

// File: doc/bus_controller.md
# bus_controller

Control unit that drives the select side of the processor datapath bus. It fetches a 9-bit instruction from DIN, sequences it over up to four steps (T0–T3), and generates the bus-driver selects consumed by the bus multiplexer: one-hot `Rout`, `Gout` and `DINout`. It also generates the matching load enables (`Rin`, `Ain`, `Gin`, `IRin`) for the registers that capture `BusWires`, plus `AddSub` and `Done`.

## Interface
Parameters:
- `DATA_W`, default 16: width of DIN.

Ports:
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `Run`  in  1  start request; sampled only in T0.
- `DIN`  in  DATA_W  instruction source; `DIN[8:0]` = III XXX YYY.
- `Rout`  out  8  one-hot bus-driver select; bit 7 = R0 … bit 0 = R7.
- `Gout`  out  1  G drives the bus.
- `DINout`  out  1  DIN drives the bus.
- `Rin`  out  8  one-hot register load enable; same bit order as `Rout`.
- `Ain`  out  1  load A from the bus.
- `Gin`  out  1  load G with the ALU result.
- `IRin`  out  1  IR capture strobe (also used internally).
- `AddSub`  out  1  0 = add, 1 = subtract.
- `Done`  out  1  last step of the current instruction.

## Operation
- Internal state:
  - 9-bit IR, captured from `DIN[8:0]` at the clock edge when in T0 with `Run` = 1.
  - 2-bit step register, encoded T0=00, T1=01, T2=10, T3=11.
- Opcodes (III):
  - 000 `mv Rx,Ry`
  - 001 `mvi Rx,#D`
  - 010 `add Rx,Ry`
  - 011 `sub Rx,Ry`
  - 1xx reserved.
- Outputs are combinational decodes of step and IR (Moore; no dependence on `Run` except `IRin`).
- T0: `IRin` = `Run`. Next state is T1 if `Run`, else T0.
- T1:
  - mv: `Rout`=onehot(Y), `Rin`=onehot(X), `Done`; then T0.
  - mvi: `DINout`, `Rin`=onehot(X), `Done`; then T0. The immediate word is on DIN during this cycle.
  - add/sub: `Rout`=onehot(X), `Ain`; then T2.
  - reserved: `Done` only, no selects; then T0.
- T2 (add/sub): `Rout`=onehot(Y), `Gin`, `AddSub` = (III==011); then T3.
- T3 (add/sub): `Gout`, `Rin`=onehot(X), `Done`; then T0.
- Bus exclusivity invariant: every cycle, at most one of {any `Rout` bit, `Gout`, `DINout`} is high, and `Rout` is either zero or exactly one-hot. `Rin` is zero or one-hot.
- Default: any output not listed for a step is 0. `AddSub` is 0 outside T2.
- X==Y is legal. mv R3,R3 gives `Rout`=`Rin`=8'b0001_0000.
- `Run` outside T0 is ignored; it does not restart or extend the instruction.
- `DIN` outside the T0 capture edge does not affect IR.

## Timing
- Reset (`Resetn` low, asynchronous): step = T0 and IR = 0 immediately. All outputs are 0 while in reset, regardless of `Clock`.
- Reset mid-instruction: the instruction is aborted with no further `Rin`/`Gin`/`Ain` pulses. After release, the controller waits in T0 for `Run`.
- Latency from the Run-sampling edge:
  - mv, mvi, reserved: `Done` in the next cycle (2 cycles including T0).
  - add/sub: `Done` 3 cycles later (4 including T0).
- Back-to-back: with `Done` high and `Run` held high, the next T0 captures a new IR on the following edge. There is no dead cycle beyond T0 itself.
- Selects are stable for the whole cycle. A downstream register loads at the edge that ends the step.

## Structure
- Shared package `proc_pkg`:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`
  - step encoding constants `T0`–`T3`
  - `REG_SEL_W` = 8
- Sub-module `dec3to8`: 3-bit index to 8-bit one-hot with MSB-first ordering (index 0 → 8'b1000_0000), plus an enable input (output 0 when disabled). Two instances, for X and Y.
- Step register and IR live in `bus_controller`.

## Test plan
- Reset: assert `Resetn`=0 mid-T2 of an add → all outputs 0 asynchronously. After release with `Run`=0, the controller stays in T0 and no `Rin` occurs.
- mv: DIN=9'b000_010_101, `Run`=1 for one cycle → T1 shows `Rout`=8'b0000_0100, `Rin`=8'b0010_0000, `Done`=1; T0 follows.
- mvi: DIN=9'b001_111_000, then DIN=16'h00A5 → T1 shows `DINout`=1, `Rin`=8'b0000_0001, `Done`=1, `Rout`=0.
- add/sub sequence: DIN=9'b011_001_011 (sub R1,R3):
  - T1: `Rout`=8'b0100_0000, `Ain`.
  - T2: `Rout`=8'b0001_0000, `Gin`, `AddSub`=1.
  - T3: `Gout`, `Rin`=8'b0100_0000, `Done`.
- Run ignored and back-to-back: pulse `Run` during T2 → no effect. Then hold `Run`=1 across `Done` → the next instruction is fetched in the following T0 with no gap.
- Invariant checker over random legal and reserved opcodes (1xx → `Done` in T1 only): at most one bus driver per cycle, and `Rout`/`Rin` are never multi-hot.
